// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches one instruction per cycle on I-cache hits, falls back to
// the memory controller on misses, predicts the next PC for JAL and conditional branches,
// and buffers fetched entries in a circular FIFO drained by dispatch via valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BHT_IDX_W = 8,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned AF_FREE   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rdy_i,
  input  logic                      clear_i,
  input  logic [31:0]               redirect_pc_i,
  output logic [31:0]               icache_addr_o,
  input  logic                      icache_hit_i,
  input  logic [31:0]               icache_inst_i,
  output logic                      icache_wr_en_o,
  output logic [31:0]               icache_wr_addr_o,
  output logic [31:0]               icache_wr_data_o,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  output logic [3:0]                mem_len_o,
  input  logic                      mem_ready_i,
  input  logic [31:0]               mem_data_i,
  output logic [BHT_IDX_W-1:0]      bht_index_o,
  input  logic                      bht_taken_i,
  output logic                      deq_valid_o,
  input  logic                      deq_ready_i,
  output logic [31:0]               deq_inst_o,
  output logic [31:0]               deq_pc_o,
  output logic [31:0]               deq_topc_o,
  output logic                      deq_pred_taken_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      almost_full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

  state_e            state_q;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       miss_addr_q, miss_addr_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;

  // Entry storage; contents only matter while counted as occupied, so no reset.
  logic [31:0]       inst_mem  [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [31:0]       topc_mem  [DEPTH];
  logic              taken_mem [DEPTH];

  logic              fetch_active;
  logic              miss;
  logic              enq;
  logic              pop;
  logic [31:0]       cand_inst;
  logic [6:0]        opcode;
  logic              is_branch;
  logic [31:0]       jimm;
  logic [31:0]       bimm;
  logic [31:0]       pred_topc;
  logic              pred_taken;
  logic [31:0]       next_pc;
  logic [CntW-1:0]   free_slots;

  // Fetch gating and the instruction being evaluated this cycle
  always_comb begin
    fetch_active = (state_q == StFetch) && (count_q < CntW'(DEPTH));
    miss         = fetch_active && !icache_hit_i;
    // In WAIT/DROP the only candidate is the memory response.
    cand_inst    = (state_q == StFetch) ? icache_inst_i : mem_data_i;
    opcode       = cand_inst[6:0];
    is_branch    = (opcode == OpBranch);
    jimm = {{11{cand_inst[31]}}, cand_inst[31], cand_inst[19:12], cand_inst[20],
            cand_inst[30:21], 1'b0};
    bimm = {{19{cand_inst[31]}}, cand_inst[31], cand_inst[7], cand_inst[30:25],
            cand_inst[11:8], 1'b0};
  end

  // Next-PC prediction for the candidate instruction
  always_comb begin
    pred_topc  = pc_q + 32'd4;
    pred_taken = 1'b0;
    next_pc    = pc_q + 32'd4;
    unique case (opcode)
      OpJal: begin
        pred_topc  = pc_q + jimm;
        pred_taken = 1'b1;
        next_pc    = pc_q + jimm;
      end
      OpBranch: begin
        pred_topc  = pc_q + bimm;
        pred_taken = bht_taken_i;
        next_pc    = bht_taken_i ? (pc_q + bimm) : (pc_q + 32'd4);
      end
      default: ;
    endcase
    bht_index_o = is_branch ? pc_q[BHT_IDX_W+1:2] : '0;
  end

  // Handshakes and memory/I-cache interface outputs
  always_comb begin
    enq = rdy_i && !clear_i &&
          ((fetch_active && icache_hit_i) || ((state_q == StWait) && mem_ready_i));
    pop = rdy_i && !clear_i && deq_valid_o && deq_ready_i;

    icache_addr_o    = fetch_active ? pc_q : 32'h0;
    // A miss cancelled by a same-cycle clear must not issue, else its response is untracked.
    mem_req_o        = rdy_i && !clear_i && miss;
    mem_addr_o       = (state_q == StFetch) ? pc_q : miss_addr_q;
    mem_len_o        = 4'd4;
    // Fill happens for every response, including ones being discarded.
    icache_wr_en_o   = rdy_i && mem_ready_i && (state_q != StFetch);
    icache_wr_addr_o = miss_addr_q;
    icache_wr_data_o = mem_data_i;
  end

  // Pointer, occupancy and PC next-state
  always_comb begin
    pc_d        = pc_q;
    miss_addr_d = miss_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (rdy_i) begin
      if (mem_req_o) begin
        miss_addr_d = pc_q;
      end
      if (clear_i) begin
        pc_d    = redirect_pc_i;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (enq) begin
          pc_d   = next_pc;
          tail_d = tail_q + PtrW'(1);
        end
        if (pop) begin
          head_d = head_q + PtrW'(1);
        end
        count_d = count_q + CntW'(enq) - CntW'(pop);
      end
    end
  end

  // Fetch FSM: FETCH looks up, WAIT expects a response, DROP discards a flushed response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else if (rdy_i) begin
      unique case (state_q)
        StFetch: if (miss && !clear_i) state_q <= StWait;
        StWait: begin
          if (mem_ready_i)  state_q <= StFetch;
          else if (clear_i) state_q <= StDrop;
        end
        StDrop:  if (mem_ready_i) state_q <= StFetch;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Architectural registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      miss_addr_q <= 32'h0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Entry write at the tail
  always_ff @(posedge clk_i) begin
    if (enq) begin
      inst_mem[tail_q]  <= cand_inst;
      pc_mem[tail_q]    <= pc_q;
      topc_mem[tail_q]  <= pred_topc;
      taken_mem[tail_q] <= pred_taken;
    end
  end

  // Head entry presentation and occupancy flags
  always_comb begin
    deq_valid_o      = (count_q != '0);
    deq_inst_o       = deq_valid_o ? inst_mem[head_q]  : 32'h0;
    deq_pc_o         = deq_valid_o ? pc_mem[head_q]    : 32'h0;
    deq_topc_o       = deq_valid_o ? topc_mem[head_q]  : 32'h0;
    deq_pred_taken_o = deq_valid_o ? taken_mem[head_q] : 1'b0;
    count_o          = count_q;
    free_slots       = CntW'(DEPTH) - count_q;
    almost_full_o    = (32'(free_slots) <= AF_FREE);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, AF_FREE=1): reset, hit stream, miss, prediction,
// full/wrap, flush during miss and rdy-low freeze.
module tb_fetch_queue;

  localparam logic [31:0] InstNop = 32'h0000_0013;
  localparam logic [31:0] InstJal = 32'h0200_006F;  // jal x0, +0x20
  localparam logic [31:0] InstBeq = 32'hFE00_0CE3;  // beq x0, x0, -8

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic [31:0] redirect_pc;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_inst;
  logic        icache_wr_en;
  logic [31:0] icache_wr_addr;
  logic [31:0] icache_wr_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_len;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [7:0]  bht_index;
  logic        bht_taken;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [31:0] deq_topc;
  logic        deq_pred_taken;
  logic [2:0]  count;
  logic        almost_full;

  logic        hit_en;
  logic        tbl_en;
  int          tests  = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  // I-cache model: NOPs everywhere, plus a JAL at 0x10 and a BEQ at 0x40 when enabled.
  assign icache_hit  = hit_en;
  assign icache_inst = (tbl_en && icache_addr == 32'h10) ? InstJal :
                       (tbl_en && icache_addr == 32'h40) ? InstBeq : InstNop;

  fetch_queue #(
    .DEPTH     (4),
    .BHT_IDX_W (8),
    .RESET_PC  (32'h0),
    .AF_FREE   (1)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rdy_i            (rdy),
    .clear_i          (clear),
    .redirect_pc_i    (redirect_pc),
    .icache_addr_o    (icache_addr),
    .icache_hit_i     (icache_hit),
    .icache_inst_i    (icache_inst),
    .icache_wr_en_o   (icache_wr_en),
    .icache_wr_addr_o (icache_wr_addr),
    .icache_wr_data_o (icache_wr_data),
    .mem_req_o        (mem_req),
    .mem_addr_o       (mem_addr),
    .mem_len_o        (mem_len),
    .mem_ready_i      (mem_ready),
    .mem_data_i       (mem_data),
    .bht_index_o      (bht_index),
    .bht_taken_i      (bht_taken),
    .deq_valid_o      (deq_valid),
    .deq_ready_i      (deq_ready),
    .deq_inst_o       (deq_inst),
    .deq_pc_o         (deq_pc),
    .deq_topc_o       (deq_topc),
    .deq_pred_taken_o (deq_pred_taken),
    .count_o          (count),
    .almost_full_o    (almost_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges, releases it just after an edge.
  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    mem_ready = 1'b0;
    rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hit_en = 1'b1; tbl_en = 1'b0; deq_ready = 1'b0; bht_taken = 1'b0;
    redirect_pc = 32'h0; mem_data = 32'h0;
    rst = 1'b1; clear = 1'b0; mem_ready = 1'b0; rdy = 1'b1;
    tick();
    tests++;
    if (deq_valid !== 1'b0) begin
      failed++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid);
    end
    tests++;
    if (count !== 3'd0) begin
      failed++; $display("FAIL reset_count: got %0d want 0", count);
    end
    tests++;
    if (mem_req !== 1'b0 || icache_wr_en !== 1'b0 || almost_full !== 1'b0) begin
      failed++; $display("FAIL reset_strobes: got req=%b wr=%b af=%b want 0/0/0",
                         mem_req, icache_wr_en, almost_full);
    end
    tests++;
    if (deq_pc !== 32'h0 || deq_inst !== 32'h0 || deq_topc !== 32'h0 ||
        deq_pred_taken !== 1'b0) begin
      failed++; $display("FAIL reset_deq_fields: got pc=%h inst=%h topc=%h pt=%b want zeros",
                         deq_pc, deq_inst, deq_topc, deq_pred_taken);
    end
    tests++;
    if (icache_addr !== 32'h0) begin
      failed++; $display("FAIL reset_icache_addr: got %h want 00000000", icache_addr);
    end
  endtask

  task automatic test_hit_stream();
    hit_en = 1'b1; tbl_en = 1'b0; deq_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * k) || count !== 3'd1) begin
        failed++; $display("FAIL hit_stream[%0d]: got v=%b pc=%h cnt=%0d want 1/%h/1",
                           k, deq_valid, deq_pc, count, 32'(4 * k));
      end
    end
  endtask

  task automatic test_miss();
    hit_en = 1'b0; tbl_en = 1'b0; deq_ready = 1'b0;
    do_reset();
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_len !== 4'd4) begin
      failed++; $display("FAIL miss_req: got req=%b addr=%h len=%0d want 1/0/4",
                         mem_req, mem_addr, mem_len);
    end
    tick();
    tests++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      failed++; $display("FAIL miss_wait_hold: got req=%b addr=%h want 0/0", mem_req, mem_addr);
    end
    repeat (4) tick();
    mem_ready = 1'b1; mem_data = 32'h0010_0093;
    #1;
    tests++;
    if (icache_wr_en !== 1'b1 || icache_wr_addr !== 32'h0 || icache_wr_data !== 32'h0010_0093)
    begin
      failed++; $display("FAIL miss_fill: got en=%b addr=%h data=%h want 1/0/00100093",
                         icache_wr_en, icache_wr_addr, icache_wr_data);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (deq_valid !== 1'b1 || deq_inst !== 32'h0010_0093 || deq_pc !== 32'h0) begin
      failed++; $display("FAIL miss_enq: got v=%b inst=%h pc=%h want 1/00100093/0",
                         deq_valid, deq_inst, deq_pc);
    end
    tests++;
    if (icache_addr !== 32'h4 || mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      failed++; $display("FAIL miss_next_lookup: got addr=%h req=%b maddr=%h want 4/1/4",
                         icache_addr, mem_req, mem_addr);
    end
  endtask

  task automatic test_prediction();
    hit_en = 1'b1; tbl_en = 1'b1; deq_ready = 1'b1; bht_taken = 1'b1;
    do_reset();
    clear = 1'b1; redirect_pc = 32'h10;
    tick();
    clear = 1'b0;
    #1;
    tests++;
    if (icache_addr !== 32'h10 || bht_index !== 8'h0 || deq_valid !== 1'b0) begin
      failed++; $display("FAIL pred_redirect: got addr=%h bht=%h v=%b want 10/00/0",
                         icache_addr, bht_index, deq_valid);
    end
    tick();
    tests++;
    if (icache_addr !== 32'h30 || deq_pc !== 32'h10 || deq_topc !== 32'h30 ||
        deq_pred_taken !== 1'b1) begin
      failed++; $display("FAIL pred_jal: got addr=%h pc=%h topc=%h pt=%b want 30/10/30/1",
                         icache_addr, deq_pc, deq_topc, deq_pred_taken);
    end
    clear = 1'b1; redirect_pc = 32'h40;
    tick();
    clear = 1'b0;
    #1;
    tests++;
    if (icache_addr !== 32'h40 || bht_index !== 8'h10) begin
      failed++; $display("FAIL pred_bht_index: got addr=%h bht=%h want 40/10",
                         icache_addr, bht_index);
    end
    tick();
    tests++;
    if (icache_addr !== 32'h38 || deq_pc !== 32'h40 || deq_topc !== 32'h38 ||
        deq_pred_taken !== 1'b1) begin
      failed++; $display("FAIL pred_beq_taken: got addr=%h pc=%h topc=%h pt=%b want 38/40/38/1",
                         icache_addr, deq_pc, deq_topc, deq_pred_taken);
    end
    bht_taken = 1'b0;
    clear = 1'b1; redirect_pc = 32'h40;
    tick();
    clear = 1'b0;
    tick();
    tests++;
    if (icache_addr !== 32'h44 || deq_pc !== 32'h40 || deq_topc !== 32'h38 ||
        deq_pred_taken !== 1'b0) begin
      failed++; $display("FAIL pred_beq_not_taken: got addr=%h pc=%h topc=%h pt=%b want 44/40/38/0",
                         icache_addr, deq_pc, deq_topc, deq_pred_taken);
    end
    tbl_en = 1'b0;
  endtask

  task automatic test_full_wrap();
    hit_en = 1'b1; tbl_en = 1'b0; deq_ready = 1'b0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++;
      if (count !== 3'(k) || almost_full !== (4 - k <= 1)) begin
        failed++; $display("FAIL full_fill[%0d]: got cnt=%0d af=%b want %0d/%b",
                           k, count, almost_full, k, (4 - k <= 1));
      end
    end
    tests++;
    if (icache_addr !== 32'h0 || mem_req !== 1'b0) begin
      failed++; $display("FAIL full_no_lookup: got addr=%h req=%b want 0/0", icache_addr, mem_req);
    end
    tick();
    tests++;
    if (count !== 3'd4) begin
      failed++; $display("FAIL full_saturate: got %0d want 4", count);
    end
    deq_ready = 1'b1;
    #1;
    tests++;
    if (icache_addr !== 32'h0) begin
      failed++; $display("FAIL full_pop_same_cycle: got addr=%h want 0", icache_addr);
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'(4 * k)) begin
        failed++; $display("FAIL wrap_order[%0d]: got v=%b pc=%h want 1/%h",
                           k, deq_valid, deq_pc, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_flush_miss();
    hit_en = 1'b0; tbl_en = 1'b0; deq_ready = 1'b1;
    do_reset();
    tick();
    clear = 1'b1; redirect_pc = 32'h200;
    tick();
    clear = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || deq_valid !== 1'b0) begin
      failed++; $display("FAIL flush_drop_idle: got req=%b v=%b want 0/0", mem_req, deq_valid);
    end
    tick();
    mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (icache_wr_en !== 1'b1 || icache_wr_addr !== 32'h0 || icache_wr_data !== 32'hDEAD_BEEF)
    begin
      failed++; $display("FAIL flush_fill: got en=%b addr=%h data=%h want 1/0/deadbeef",
                         icache_wr_en, icache_wr_addr, icache_wr_data);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || deq_valid !== 1'b0) begin
      failed++; $display("FAIL flush_discard: got cnt=%0d v=%b want 0/0", count, deq_valid);
    end
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
      failed++; $display("FAIL flush_new_req: got req=%b addr=%h want 1/200", mem_req, mem_addr);
    end
  endtask

  task automatic test_rdy_low();
    hit_en = 1'b1; tbl_en = 1'b0; deq_ready = 1'b0;
    do_reset();
    tick();
    tick();
    rdy = 1'b0; clear = 1'b1; redirect_pc = 32'h300; hit_en = 1'b0; deq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (mem_req !== 1'b0 || count !== 3'd2 || deq_valid !== 1'b1 || deq_pc !== 32'h0) begin
        failed++; $display("FAIL rdy_low[%0d]: got req=%b cnt=%0d v=%b pc=%h want 0/2/1/0",
                           k, mem_req, count, deq_valid, deq_pc);
      end
      tick();
    end
    rdy = 1'b1; clear = 1'b0; hit_en = 1'b1; deq_ready = 1'b0;
    #1;
    tests++;
    if (icache_addr !== 32'h8 || count !== 3'd2) begin
      failed++; $display("FAIL rdy_resume: got addr=%h cnt=%0d want 8/2", icache_addr, count);
    end
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_miss();
    test_prediction();
    test_full_wrap();
    test_flush_miss();
    test_rdy_low();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end want end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue for the out-of-order RISC-V core, placed between the I-cache/memory controller and the dispatch stage. It fetches one instruction per cycle on I-cache hits, falls back to a memory-controller request on misses, and predicts the next PC for JAL and conditional branches. Entries are buffered in a circular FIFO of configurable depth and presented to dispatch through a valid/ready handshake. A `clear` redirect flushes the queue and safely discards an outstanding memory response.

## Interface
- `DEPTH`, 32, number of queue entries; power of two, ≥2.
- `BHT_IDX_W`, 8, BHT index width.
- `RESET_PC`, 32'h0, fetch PC after reset.
- `AF_FREE`, 4, `almost_full` asserts when free slots ≤ this value.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable; low freezes all state.
- `clear` in 1: flush plus redirect.
- `redirect_pc` in 32: new fetch PC on `clear`.
- `icache_addr` out 32: lookup address.
- `icache_hit` in 1: combinational hit.
- `icache_inst` in 32: hit data.
- `icache_wr_en` out 1: fill strobe.
- `icache_wr_addr` out 32: fill address.
- `icache_wr_data` out 32: fill data.
- `mem_req` out 1: one-cycle request pulse.
- `mem_addr` out 32: request address; held while waiting.
- `mem_len` out 4: constant 4.
- `mem_ready` in 1: response valid for one cycle.
- `mem_data` in 32: response data.
- `bht_index` out `BHT_IDX_W`: `pc[BHT_IDX_W+1:2]`.
- `bht_taken` in 1: combinational prediction.
- `deq_valid` out 1: head entry valid.
- `deq_ready` in 1: dispatch accepts the head entry.
- `deq_inst` out 32, `deq_pc` out 32, `deq_topc` out 32, `deq_pred_taken` out 1: fields of the head entry.
- `count` out `$clog2(DEPTH)+1`: occupancy.
- `almost_full` out 1: `(DEPTH-count) ≤ AF_FREE`.

## Operation
- **State:** `pc`, `head`, `tail`, `count`, and an FSM with states FETCH, WAIT, DROP.
- **FETCH:**
  - Active only when `count<DEPTH`; the check uses the registered `count`.
  - Drives `icache_addr=pc`.
  - Hit: enqueue `icache_inst` at the same edge and update `pc`; stay in FETCH.
  - Miss: `mem_req=1`, `mem_addr=pc`, go to WAIT.
  - `count==DEPTH`: no lookup, `icache_addr=0`.
- **WAIT:** on `mem_ready`:
  - enqueue `mem_data`;
  - assert `icache_wr_en` with `wr_addr=pc` and `wr_data=mem_data`;
  - update `pc`;
  - go to FETCH.
  - No slot reservation is needed, because only dequeue changes `count` while waiting.
- **DROP:** on `mem_ready`:
  - fill the I-cache normally;
  - do not enqueue;
  - do not change `pc`;
  - go to FETCH.
- **Next-PC prediction** (for the instruction being enqueued; `opcode=inst[6:0]`):
  - 1101111 (JAL): `topc=pc+Jimm`, `pred_taken=1`, `pc<=topc`.
  - 1100011 (branch): `topc=pc+Bimm`; `pred_taken=bht_taken`; `pc<=taken?topc:pc+4`. `bht_index` is driven only in this case, otherwise 0.
  - 1100111 (JALR): `topc=pc+4`, `pred_taken=0`, `pc<=pc+4`.
  - Others: `topc=pc+4`, `pred_taken=0`, `pc<=pc+4`.
  - All immediates are sign-extended; additions are 32-bit, wrapping.
- **Dequeue:** a pop happens on `deq_valid&&deq_ready`. `deq_*` fields are read combinationally from `head`.
- **Pointers** wrap modulo DEPTH; `count <= count + enq - pop`.
- **`clear`** (when `rdy`=1):
  - `head=tail=count=0`, `pc<=redirect_pc`;
  - any same-cycle enqueue and pop are cancelled;
  - WAIT→DROP; WAIT with `mem_ready` in the same cycle → FETCH, response discarded but cache fill still performed;
  - FETCH/DROP keep their state. A DROP state with `mem_ready` in the same cycle goes to FETCH.
- **`rdy`=0:**
  - no state changes;
  - `clear`, `mem_ready` and pops are ignored;
  - `mem_req` and `icache_wr_en` are forced to 0.
  - The memory controller holds `mem_ready` until `rdy` returns.
- **Reset values:**
  - `pc=RESET_PC`, FSM=FETCH, `head=tail=count=0`;
  - outputs: `deq_valid=0`, `mem_req=0`, `icache_wr_en=0`, `almost_full=0`, `count=0`; all `deq_*` fields 0.
- **Reset mid-operation:** the outstanding memory response is not tracked after reset. The memory controller is reset by the same `rst`.

## Timing
- Hit path: a lookup in cycle N enqueues at the end of N; `deq_valid` rises in N+1. Sustained throughput is 1 instruction per cycle.
- Miss path: `mem_req` pulses in cycle N; `mem_ready` arrives in cycle M; the entry is visible in M+1; the next lookup happens in M+1.
- Enqueue and dequeue in the same cycle are both permitted. When full, a pop frees a slot but fetch resumes only in the next cycle.
- `clear` at edge N: `deq_valid=0` in N+1; the first lookup at `redirect_pc` happens in N+1 if the FSM is in FETCH.

## Test plan
- **Hit stream:** reset, always hit, non-branch instructions, `deq_ready=1`.
  - Required: `deq_pc` = 0, 4, 8, … every cycle from cycle 2; `count` steady at 1.
- **Miss:** `icache_hit=0`.
  - Required: `mem_req` pulse with `mem_addr=0`; `mem_ready` 5 cycles later with `mem_data=32'h00100093`; `icache_wr_en=1` with `addr=0`; `deq_inst=32'h00100093` one cycle after `mem_ready`.
- **Prediction:** JAL at pc 0x10 with imm +0x20 → next lookup at 0x30. BEQ at 0x40 with imm −8 and `bht_taken=1` → 0x38, `deq_pred_taken=1`, `bht_index=0x10`. With `bht_taken=0` → 0x44.
- **Full/wrap:** DEPTH=4, `deq_ready=0`, always hit.
  - Required: `count` saturates at 4; `icache_addr=0` while full; `almost_full` follows AF_FREE.
  - Then pop 1 per cycle: `deq_pc` order preserved across wrap.
- **Flush during miss:** `clear` with `redirect_pc=0x200` while in WAIT; a later `mem_ready` is not enqueued but the cache is filled; the next `mem_req` uses `mem_addr=0x200`.
- **`rdy` low:** deassert for 3 cycles mid-stream.
  - Required: `count`, `pc` and `deq_*` are unchanged; `mem_req=0`; `clear` during this window has no effect.
